// File: rtl/pu_check_scheduler_pkg.sv
// Shared types for the protection-unit policy-check scheduler.
// axi_pkg carries the AXI burst field types referenced by the check request.
package axi_pkg;
    typedef logic [7:0] len_t;
    typedef logic [2:0] size_t;
endpackage

package pu_pkg;
    localparam int unsigned PU_ID_WIDTH   = 16;
    localparam int unsigned PU_ADDR_WIDTH = 32;

    typedef logic [PU_ID_WIDTH-1:0]   id_t;
    typedef logic [PU_ADDR_WIDTH-1:0] addr_t;

    typedef struct packed {
        id_t            id;
        addr_t          addr;
        axi_pkg::len_t  len;
        axi_pkg::size_t size;
    } chk_req_t;

    typedef enum logic [1:0] {IDLE, CHECK, RESP} chk_state_e;
    typedef enum logic {OWN_READ = 1'b0, OWN_WRITE = 1'b1} chk_owner_e;
endpackage

// File: rtl/pu_rr_arb2.sv
// Two-input round-robin arbiter; bit 0 is the read side, bit 1 the write side.
// On a tie the pointer side wins; after each accept the pointer moves away from the winner.
import pu_pkg::*;

module pu_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    chk_owner_e ptr;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (ptr == OWN_READ) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= OWN_READ;
        end else if (advance && (gnt != 2'b00)) begin
            ptr <= gnt[0] ? OWN_WRITE : OWN_READ;
        end
    end
endmodule

// File: rtl/pu_check_scheduler.sv
// Time-shares one combinational policy checker between the AR and AW requesters:
// accept (IDLE) -> drive checker and capture verdict (CHECK) -> return verdict (RESP).
import pu_pkg::*;

module pu_check_scheduler #(
    parameter int unsigned ID_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RD_REQ_VALID,
    output logic                  RD_REQ_READY,
    input  chk_req_t              RD_REQ,
    output logic                  RD_RES_VALID,
    input  logic                  RD_RES_READY,
    output logic                  RD_RES_GRANTED,
    input  logic                  WR_REQ_VALID,
    output logic                  WR_REQ_READY,
    input  chk_req_t              WR_REQ,
    output logic                  WR_RES_VALID,
    input  logic                  WR_RES_READY,
    output logic                  WR_RES_GRANTED,
    output logic [ID_WIDTH-1:0]   CHK_ID,
    output logic [ADDR_WIDTH-1:0] CHK_ADDR,
    output logic [7:0]            CHK_LEN,
    output logic [2:0]            CHK_SIZE,
    output logic                  CHK_READ_WRITE,
    input  logic                  CHK_GRANTED
);
    chk_state_e state_q, state_d;
    chk_owner_e owner_q;
    chk_req_t   req_q;
    logic       res_q;
    logic [1:0] gnt;
    logic       accept;
    logic       rd_res_vld, wr_res_vld;

    pu_rr_arb2 u_arb (
        .clk     (CLK),
        .rst     (RST),
        .req     ({WR_REQ_VALID, RD_REQ_VALID}),
        .advance (accept),
        .gnt     (gnt)
    );

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        RD_REQ_READY = 1'b0;
        WR_REQ_READY = 1'b0;
        rd_res_vld   = 1'b0;
        wr_res_vld   = 1'b0;
        case (state_q)
            IDLE: begin
                if (RD_REQ_VALID || WR_REQ_VALID) begin
                    accept       = 1'b1;
                    RD_REQ_READY = gnt[0];
                    WR_REQ_READY = gnt[1];
                    state_d      = CHECK;
                end
            end
            CHECK: state_d = RESP;
            RESP: begin
                rd_res_vld = (owner_q == OWN_READ);
                wr_res_vld = (owner_q == OWN_WRITE);
                if ((rd_res_vld && RD_RES_READY) || (wr_res_vld && WR_RES_READY)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            owner_q <= OWN_READ;
            req_q   <= '0;
            res_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_q   <= gnt[1] ? WR_REQ : RD_REQ;
                owner_q <= gnt[1] ? OWN_WRITE : OWN_READ;
            end
            if (state_q == CHECK) begin
                res_q <= CHK_GRANTED;
            end
        end
    end

    // req_q/owner_q only change on accept, so the checker inputs hold outside CHECK.
    assign CHK_ID         = ID_WIDTH'(req_q.id);
    assign CHK_ADDR       = ADDR_WIDTH'(req_q.addr);
    assign CHK_LEN        = req_q.len;
    assign CHK_SIZE       = req_q.size;
    assign CHK_READ_WRITE = owner_q;

    assign RD_RES_VALID   = rd_res_vld;
    assign WR_RES_VALID   = wr_res_vld;
    assign RD_RES_GRANTED = rd_res_vld & res_q;
    assign WR_RES_GRANTED = wr_res_vld & res_q;

    a_single_owner: assert property (@(posedge CLK) disable iff (RST)
        !$isunknown(owner_q) && !(RD_RES_VALID && WR_RES_VALID));
endmodule

// File: tb/tb_pu_check_scheduler.sv
// Self-checking bench for pu_check_scheduler: directed scenarios plus randomized
// transactions checked against a transaction-level arbitration/verdict model.
module tb_pu_check_scheduler;
    import pu_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        RD_REQ_VALID, RD_REQ_READY, RD_RES_VALID, RD_RES_READY, RD_RES_GRANTED;
    logic        WR_REQ_VALID, WR_REQ_READY, WR_RES_VALID, WR_RES_READY, WR_RES_GRANTED;
    chk_req_t    RD_REQ, WR_REQ;
    logic [15:0] CHK_ID;
    logic [31:0] CHK_ADDR;
    logic [7:0]  CHK_LEN;
    logic [2:0]  CHK_SIZE;
    logic        CHK_READ_WRITE, CHK_GRANTED;
    logic        use_policy, grant_drv;

    int tests = 0;
    int fails = 0;
    chk_owner_e prio;

    always #5 CLK = ~CLK;

    // Checker stand-in: deny IDs ending in F, and writes to the upper half of the map.
    function automatic logic policy(input logic [15:0] id, input logic [31:0] addr, input logic rw);
        return (id[3:0] != 4'hF) && !(rw && addr[31]);
    endfunction

    assign CHK_GRANTED = use_policy ? policy(CHK_ID, CHK_ADDR, CHK_READ_WRITE) : grant_drv;

    pu_check_scheduler #(.ID_WIDTH(16), .ADDR_WIDTH(32)) dut (
        .CLK(CLK), .RST(RST),
        .RD_REQ_VALID(RD_REQ_VALID), .RD_REQ_READY(RD_REQ_READY), .RD_REQ(RD_REQ),
        .RD_RES_VALID(RD_RES_VALID), .RD_RES_READY(RD_RES_READY), .RD_RES_GRANTED(RD_RES_GRANTED),
        .WR_REQ_VALID(WR_REQ_VALID), .WR_REQ_READY(WR_REQ_READY), .WR_REQ(WR_REQ),
        .WR_RES_VALID(WR_RES_VALID), .WR_RES_READY(WR_RES_READY), .WR_RES_GRANTED(WR_RES_GRANTED),
        .CHK_ID(CHK_ID), .CHK_ADDR(CHK_ADDR), .CHK_LEN(CHK_LEN), .CHK_SIZE(CHK_SIZE),
        .CHK_READ_WRITE(CHK_READ_WRITE), .CHK_GRANTED(CHK_GRANTED)
    );

    // Inputs change at posedge+1; outputs are sampled at the following negedge.
    task automatic next_cycle;
        @(posedge CLK);
        #1;
    endtask

    task automatic sample;
        @(negedge CLK);
    endtask

    function automatic chk_req_t rand_req();
        chk_req_t r;
        r.id      = 16'($urandom);
        r.id[3:0] = 4'($urandom_range(12, 15));
        r.addr    = $urandom;
        r.len     = 8'($urandom);
        r.size    = 3'($urandom);
        return r;
    endfunction

    task automatic apply_reset;
        RST = 1'b1;
        RD_REQ_VALID = 1'b0; WR_REQ_VALID = 1'b0;
        RD_RES_READY = 1'b0; WR_RES_READY = 1'b0;
        next_cycle;
        next_cycle;
        RST = 1'b0;
        prio = OWN_READ;
    endtask

    task automatic test_reset;
        RD_REQ = '0; WR_REQ = '0; use_policy = 1'b0; grant_drv = 1'b1;
        apply_reset;
        sample;
        tests++;
        if ({RD_REQ_READY, WR_REQ_READY, RD_RES_VALID, WR_RES_VALID, RD_RES_GRANTED, WR_RES_GRANTED} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl got %b exp 000000", {RD_REQ_READY, WR_REQ_READY, RD_RES_VALID, WR_RES_VALID, RD_RES_GRANTED, WR_RES_GRANTED});
        end
        tests++;
        if ({CHK_ID, CHK_ADDR, CHK_LEN, CHK_SIZE, CHK_READ_WRITE} !== 60'h0) begin
            fails++;
            $display("FAIL reset_chk got %h exp 0", {CHK_ID, CHK_ADDR, CHK_LEN, CHK_SIZE, CHK_READ_WRITE});
        end
        next_cycle;
    endtask

    task automatic test_single_read;
        use_policy = 1'b0; grant_drv = 1'b1;
        RD_REQ = '{id: 16'h0003, addr: 32'h4000_0000, len: 8'd0, size: 3'd2};
        RD_REQ_VALID = 1'b1;
        sample;
        tests++;
        if ({RD_REQ_READY, WR_REQ_READY} !== 2'b10) begin
            fails++; $display("FAIL single_accept got %b exp 10", {RD_REQ_READY, WR_REQ_READY});
        end
        next_cycle;
        RD_REQ_VALID = 1'b0;
        sample;
        tests++;
        if ({CHK_ID, CHK_ADDR, CHK_LEN, CHK_SIZE, CHK_READ_WRITE, RD_RES_VALID} !== {16'h0003, 32'h4000_0000, 8'd0, 3'd2, 1'b0, 1'b0}) begin
            fails++; $display("FAIL single_check got %h exp %h", {CHK_ID, CHK_ADDR, CHK_LEN, CHK_SIZE, CHK_READ_WRITE, RD_RES_VALID},
                              {16'h0003, 32'h4000_0000, 8'd0, 3'd2, 1'b0, 1'b0});
        end
        next_cycle;
        sample;
        tests++;
        if ({RD_RES_VALID, RD_RES_GRANTED, WR_RES_VALID, WR_RES_GRANTED} !== 4'b1100) begin
            fails++; $display("FAIL single_resp got %b exp 1100", {RD_RES_VALID, RD_RES_GRANTED, WR_RES_VALID, WR_RES_GRANTED});
        end
        RD_RES_READY = 1'b1;
        next_cycle;
        RD_RES_READY = 1'b0;
        sample;
        tests++;
        if (RD_RES_VALID !== 1'b0) begin
            fails++; $display("FAIL single_done got %b exp 0", RD_RES_VALID);
        end
        next_cycle;
        prio = OWN_WRITE;
    endtask

    task automatic test_simultaneous;
        chk_owner_e exp_win;
        chk_req_t   cur;
        logic       g;
        apply_reset;
        use_policy = 1'b1;
        RD_REQ = '{id: 16'h0011, addr: 32'h8000_1000, len: 8'd3, size: 3'd2};
        WR_REQ = '{id: 16'h0022, addr: 32'h8000_2000, len: 8'd7, size: 3'd3};
        RD_REQ_VALID = 1'b1; WR_REQ_VALID = 1'b1;
        RD_RES_READY = 1'b1; WR_RES_READY = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            exp_win = (k % 2 == 0) ? OWN_READ : OWN_WRITE;
            cur = (exp_win == OWN_READ) ? RD_REQ : WR_REQ;
            g = policy(cur.id, cur.addr, exp_win);
            sample;
            tests++;
            if ({RD_REQ_READY, WR_REQ_READY} !== ((exp_win == OWN_READ) ? 2'b10 : 2'b01)) begin
                fails++; $display("FAIL simul_win[%0d] got %b exp_owner %0d", k, {RD_REQ_READY, WR_REQ_READY}, exp_win);
            end
            next_cycle;
            sample;
            tests++;
            if (CHK_READ_WRITE !== logic'(exp_win)) begin
                fails++; $display("FAIL simul_rw[%0d] got %b exp %b", k, CHK_READ_WRITE, exp_win);
            end
            next_cycle;
            sample;
            tests++;
            if ({RD_RES_VALID, RD_RES_GRANTED, WR_RES_VALID, WR_RES_GRANTED} !==
                ((exp_win == OWN_READ) ? {1'b1, g, 2'b00} : {2'b00, 1'b1, g})) begin
                fails++; $display("FAIL simul_resp[%0d] got %b g=%b", k, {RD_RES_VALID, RD_RES_GRANTED, WR_RES_VALID, WR_RES_GRANTED}, g);
            end
            next_cycle;
        end
        RD_REQ_VALID = 1'b0; WR_REQ_VALID = 1'b0;
        RD_RES_READY = 1'b0; WR_RES_READY = 1'b0;
        prio = OWN_READ;
    endtask

    task automatic test_deny;
        use_policy = 1'b0; grant_drv = 1'b0;
        WR_REQ = '{id: 16'h0005, addr: 32'h0000_0040, len: 8'd1, size: 3'd2};
        WR_REQ_VALID = 1'b1;
        sample;
        tests++;
        if ({RD_REQ_READY, WR_REQ_READY} !== 2'b01) begin
            fails++; $display("FAIL deny_accept got %b exp 01", {RD_REQ_READY, WR_REQ_READY});
        end
        next_cycle;
        WR_REQ_VALID = 1'b0;
        sample;
        tests++;
        if (CHK_READ_WRITE !== 1'b1) begin
            fails++; $display("FAIL deny_rw got %b exp 1", CHK_READ_WRITE);
        end
        next_cycle;
        sample;
        tests++;
        if ({RD_RES_VALID, RD_RES_GRANTED, WR_RES_VALID, WR_RES_GRANTED} !== 4'b0010) begin
            fails++; $display("FAIL deny_resp got %b exp 0010", {RD_RES_VALID, RD_RES_GRANTED, WR_RES_VALID, WR_RES_GRANTED});
        end
        WR_RES_READY = 1'b1;
        next_cycle;
        WR_RES_READY = 1'b0;
        prio = OWN_READ;
    endtask

    task automatic test_backpressure;
        use_policy = 1'b0; grant_drv = 1'b1;
        RD_REQ = '{id: 16'h0100, addr: 32'h1234_5678, len: 8'd15, size: 3'd3};
        WR_REQ = '{id: 16'h0200, addr: 32'h0000_8000, len: 8'd0, size: 3'd0};
        RD_REQ_VALID = 1'b1;
        next_cycle;
        RD_REQ_VALID = 1'b0;
        next_cycle;
        // Checker verdict flips after CHECK and must not leak into the held response.
        grant_drv = 1'b0;
        WR_REQ_VALID = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            sample;
            tests++;
            if ({RD_RES_VALID, RD_RES_GRANTED, WR_REQ_READY} !== 3'b110) begin
                fails++; $display("FAIL bp_hold[%0d] got %b exp 110", i, {RD_RES_VALID, RD_RES_GRANTED, WR_REQ_READY});
            end
            next_cycle;
        end
        RD_RES_READY = 1'b1;
        sample;
        tests++;
        if ({RD_RES_VALID, WR_REQ_READY} !== 2'b10) begin
            fails++; $display("FAIL bp_handshake got %b exp 10", {RD_RES_VALID, WR_REQ_READY});
        end
        next_cycle;
        RD_RES_READY = 1'b0;
        sample;
        tests++;
        if ({RD_RES_VALID, WR_REQ_READY} !== 2'b01) begin
            fails++; $display("FAIL bp_wr_accept got %b exp 01", {RD_RES_VALID, WR_REQ_READY});
        end
        next_cycle;
        WR_REQ_VALID = 1'b0;
        next_cycle;
        WR_RES_READY = 1'b1;
        next_cycle;
        WR_RES_READY = 1'b0;
        prio = OWN_READ;
    endtask

    task automatic test_reset_midop;
        use_policy = 1'b0; grant_drv = 1'b1;
        RD_REQ = '{id: 16'h0033, addr: 32'h0000_3000, len: 8'd2, size: 3'd1};
        WR_REQ = '{id: 16'h0044, addr: 32'h0000_4000, len: 8'd4, size: 3'd2};
        for (int unsigned ph = 0; ph < 2; ph++) begin
            RD_REQ_VALID = 1'b1;
            next_cycle;
            RD_REQ_VALID = 1'b0;
            if (ph == 1) next_cycle;
            RST = 1'b1;
            next_cycle;
            RST = 1'b0;
            sample;
            tests++;
            if ({RD_REQ_READY, WR_REQ_READY, RD_RES_VALID, WR_RES_VALID, RD_RES_GRANTED, WR_RES_GRANTED,
                 CHK_ID, CHK_ADDR, CHK_LEN, CHK_SIZE, CHK_READ_WRITE} !== 66'h0) begin
                fails++; $display("FAIL midrst_out[%0d] got %h exp 0", ph, {RD_REQ_READY, WR_REQ_READY, RD_RES_VALID, WR_RES_VALID,
                                  RD_RES_GRANTED, WR_RES_GRANTED, CHK_ID, CHK_ADDR, CHK_LEN, CHK_SIZE, CHK_READ_WRITE});
            end
            for (int unsigned i = 0; i < 3; i++) begin
                next_cycle;
                sample;
                tests++;
                if ({RD_RES_VALID, WR_RES_VALID} !== 2'b00) begin
                    fails++; $display("FAIL midrst_dropped[%0d] got %b exp 00", ph, {RD_RES_VALID, WR_RES_VALID});
                end
            end
            next_cycle;
            RD_REQ_VALID = 1'b1; WR_REQ_VALID = 1'b1;
            sample;
            tests++;
            if ({RD_REQ_READY, WR_REQ_READY} !== 2'b10) begin
                fails++; $display("FAIL midrst_ptr[%0d] got %b exp 10", ph, {RD_REQ_READY, WR_REQ_READY});
            end
            next_cycle;
            RD_REQ_VALID = 1'b0; WR_REQ_VALID = 1'b0;
            next_cycle;
            RD_RES_READY = 1'b1;
            next_cycle;
            RD_RES_READY = 1'b0;
        end
        prio = OWN_WRITE;
    endtask

    task automatic test_withdraw;
        use_policy = 1'b1;
        RD_REQ = '{id: 16'h0066, addr: 32'h0000_6000, len: 8'd0, size: 3'd2};
        RD_REQ_VALID = 1'b1;
        next_cycle;
        RD_REQ_VALID = 1'b0;
        next_cycle;
        WR_REQ_VALID = 1'b1;
        sample;
        tests++;
        if ({WR_REQ_READY, RD_RES_VALID} !== 2'b01) begin
            fails++; $display("FAIL withdraw_pulse got %b exp 01", {WR_REQ_READY, RD_RES_VALID});
        end
        next_cycle;
        WR_REQ_VALID = 1'b0;
        RD_RES_READY = 1'b1;
        next_cycle;
        RD_RES_READY = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            sample;
            tests++;
            if ({WR_RES_VALID, WR_REQ_READY, RD_REQ_READY, RD_RES_VALID} !== 4'b0) begin
                fails++; $display("FAIL withdraw_quiet[%0d] got %b exp 0000", i, {WR_RES_VALID, WR_REQ_READY, RD_REQ_READY, RD_RES_VALID});
            end
            next_cycle;
        end
        prio = OWN_WRITE;
    endtask

    task automatic test_random;
        logic       pend_r, pend_w, g;
        chk_req_t   rq, wq, cur;
        chk_owner_e win;
        int unsigned bp;
        apply_reset;
        use_policy = 1'b1;
        pend_r = 1'b0; pend_w = 1'b0; rq = '0; wq = '0;
        for (int unsigned it = 0; it < 60; it++) begin
            if ((!pend_r && !pend_w) || ($urandom_range(0, 1) == 1)) begin
                if (!pend_r && ($urandom_range(0, 1) == 1)) begin pend_r = 1'b1; rq = rand_req(); end
                if (!pend_w && ($urandom_range(0, 1) == 1)) begin pend_w = 1'b1; wq = rand_req(); end
                if (!pend_r && !pend_w) begin pend_w = 1'b1; wq = rand_req(); end
            end
            RD_REQ_VALID = pend_r; RD_REQ = rq;
            WR_REQ_VALID = pend_w; WR_REQ = wq;
            win = (pend_r && pend_w) ? prio : (pend_r ? OWN_READ : OWN_WRITE);
            cur = (win == OWN_READ) ? rq : wq;
            g   = policy(cur.id, cur.addr, win);
            sample;
            tests++;
            if ({RD_REQ_READY, WR_REQ_READY} !== ((win == OWN_READ) ? 2'b10 : 2'b01)) begin
                fails++; $display("FAIL rand_win[%0d] got %b exp_owner %0d", it, {RD_REQ_READY, WR_REQ_READY}, win);
            end
            prio = (win == OWN_READ) ? OWN_WRITE : OWN_READ;
            if (win == OWN_READ) pend_r = 1'b0; else pend_w = 1'b0;
            next_cycle;
            RD_REQ_VALID = pend_r; WR_REQ_VALID = pend_w;
            sample;
            tests++;
            if ({CHK_ID, CHK_ADDR, CHK_LEN, CHK_SIZE, CHK_READ_WRITE, RD_REQ_READY, WR_REQ_READY} !== {cur, logic'(win), 2'b00}) begin
                fails++; $display("FAIL rand_check[%0d] got %h exp %h", it,
                                  {CHK_ID, CHK_ADDR, CHK_LEN, CHK_SIZE, CHK_READ_WRITE, RD_REQ_READY, WR_REQ_READY}, {cur, logic'(win), 2'b00});
            end
            bp = $urandom_range(0, 3);
            next_cycle;
            for (int unsigned i = 0; i <= bp; i++) begin
                if (i == bp) begin
                    if (win == OWN_READ) RD_RES_READY = 1'b1; else WR_RES_READY = 1'b1;
                end
                sample;
                tests++;
                if ({RD_RES_VALID, RD_RES_GRANTED, WR_RES_VALID, WR_RES_GRANTED, RD_REQ_READY, WR_REQ_READY} !==
                    ((win == OWN_READ) ? {1'b1, g, 4'b0000} : {2'b00, 1'b1, g, 2'b00})) begin
                    fails++; $display("FAIL rand_resp[%0d] got %b owner %0d g=%b", it,
                                      {RD_RES_VALID, RD_RES_GRANTED, WR_RES_VALID, WR_RES_GRANTED, RD_REQ_READY, WR_REQ_READY}, win, g);
                end
                next_cycle;
            end
            RD_RES_READY = 1'b0; WR_RES_READY = 1'b0;
        end
        RD_REQ_VALID = 1'b0; WR_REQ_VALID = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_single_read;
        test_simultaneous;
        test_deny;
        test_backpressure;
        test_reset_midop;
        test_withdraw;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
